// File: rtl/result_collector.sv
// Captures control-stage results tagged with their mode into a first-word fall-through FIFO.
// Optional carry/borrow statistics are compiled in when RC_STATS_EN is defined.
module result_collector #(
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic [1:0]               modo,
    input  logic [3:0]               Q,
    input  logic                     RCO,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [3:0]               out_Q,
    output logic                     out_RCO,
    output logic [1:0]               out_modo,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
`ifdef RC_STATS_EN
    ,
    output logic [CW-1:0]            carry_cnt,
    output logic [CW-1:0]            borrow_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_collector: DEPTH must be a power of two >= 2");
    end
    if (CW < 1) begin : g_bad_cw
        $error("result_collector: CW must be >= 1");
    end

    logic            pend;
    logic [1:0]      pend_modo;
    logic [6:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [6:0]      wdata;
    logic [6:0]      head;
    logic            pop;
    logic            accept;
    logic            drop;

    // A clear reports zero regardless of what the result bus carries
    assign wdata  = (pend_modo == 2'b11) ? 7'b1100000 : {pend_modo, RCO, Q};
    assign pop    = out_vld & out_rdy;
    assign accept = pend & (!full | pop);
    assign drop   = pend & full & !pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign out_vld = !empty;

    assign head     = empty ? 7'b0 : mem[rd_ptr];
    assign out_modo = head[6:5];
    assign out_RCO  = head[4];
    assign out_Q    = head[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_modo <= 2'b00;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end else begin
            pend      <= enb & (modo != 2'b00);
            pend_modo <= modo;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (!rst && accept) mem[wr_ptr] <= wdata;
    end

`ifdef RC_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_cnt  <= '0;
            borrow_cnt <= '0;
        end else if (accept && wdata[4]) begin
            if (wdata[6:5] == 2'b01 && carry_cnt != '1)
                carry_cnt <= carry_cnt + 1'b1;
            if (wdata[6:5] == 2'b10 && borrow_cnt != '1)
                borrow_cnt <= borrow_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: models the upstream add/sub stage and checks the
// FIFO against a queue-based reference, with directed scenarios and random traffic.
module tb_result_collector;

    localparam int DEPTH = 4;
    localparam int CW    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enb = 1'b0;
    logic [1:0] modo = 2'b00;
    logic [3:0] cq = 4'h0;
    logic       crco = 1'b0;
    logic       out_rdy = 1'b0;
    logic       out_vld;
    logic [3:0] out_Q;
    logic       out_RCO;
    logic [1:0] out_modo;
    logic [$clog2(DEPTH):0] count;
    logic       full, empty, ovf;
`ifdef RC_STATS_EN
    logic [CW-1:0] carry_cnt, borrow_cnt;
    logic       vld2, rco2, full2, empty2, ovf2;
    logic [3:0] q2;
    logic [1:0] modo2;
    logic [$clog2(DEPTH):0] count2;
    logic [1:0] carry2, borrow2;
    int         carry2_m, borrow2_m;
`endif

    int cmps = 0;
    int errs = 0;

    logic [6:0] q_m[$];
    logic       ovf_m, pend_m;
    logic [1:0] pmodo_m;
    int         carry_m, borrow_m;

    always #5 clk = ~clk;

    result_collector #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .enb(enb), .modo(modo), .Q(cq), .RCO(crco),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_Q(out_Q), .out_RCO(out_RCO),
        .out_modo(out_modo), .count(count), .full(full), .empty(empty), .ovf(ovf)
`ifdef RC_STATS_EN
        , .carry_cnt(carry_cnt), .borrow_cnt(borrow_cnt)
`endif
    );

`ifdef RC_STATS_EN
    result_collector #(.DEPTH(DEPTH), .CW(2)) dut2 (
        .clk(clk), .rst(rst), .enb(enb), .modo(modo), .Q(cq), .RCO(crco),
        .out_vld(vld2), .out_rdy(out_rdy), .out_Q(q2), .out_RCO(rco2),
        .out_modo(modo2), .count(count2), .full(full2), .empty(empty2), .ovf(ovf2),
        .carry_cnt(carry2), .borrow_cnt(borrow2)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, advance the model, compare.
    task automatic cyc(input logic e, input logic [1:0] m, input logic [3:0] a,
                       input logic [3:0] b, input logic r);
        logic [4:0] s;
        logic [6:0] h;
        enb = e; modo = m; out_rdy = r;
        @(posedge clk);
        #1;
        if (rst) begin
            q_m.delete();
            ovf_m = 1'b0; pend_m = 1'b0; pmodo_m = 2'b00;
            carry_m = 0; borrow_m = 0;
`ifdef RC_STATS_EN
            carry2_m = 0; borrow2_m = 0;
`endif
            cq = 4'h0; crco = 1'b0;
        end else begin
            if (q_m.size() != 0 && r) void'(q_m.pop_front());
            if (pend_m) begin
                if (q_m.size() < DEPTH) begin
                    q_m.push_back({pmodo_m, crco, cq});
                    if (crco && pmodo_m == 2'b01) begin
                        carry_m = (carry_m < 255) ? carry_m + 1 : 255;
`ifdef RC_STATS_EN
                        carry2_m = (carry2_m < 3) ? carry2_m + 1 : 3;
`endif
                    end
                    if (crco && pmodo_m == 2'b10) begin
                        borrow_m = (borrow_m < 255) ? borrow_m + 1 : 255;
`ifdef RC_STATS_EN
                        borrow2_m = (borrow2_m < 3) ? borrow2_m + 1 : 3;
`endif
                    end
                end else begin
                    ovf_m = 1'b1;
                end
            end
            pend_m  = e && (m != 2'b00);
            pmodo_m = m;
            if (e) begin
                case (m)
                    2'b01: begin s = {1'b0, a} + {1'b0, b}; cq = s[3:0]; crco = s[4]; end
                    2'b10: begin cq = a - b; crco = (a < b); end
                    2'b11: begin cq = 4'h0; crco = 1'b0; end
                    default: ;
                endcase
            end
        end
        chk("out_vld", out_vld, q_m.size() != 0);
        chk("count", count, q_m.size());
        chk("full", full, q_m.size() == DEPTH);
        chk("empty", empty, q_m.size() == 0);
        chk("ovf", ovf, ovf_m);
        if (q_m.size() != 0) begin
            h = q_m[0];
            chk("head_Q", out_Q, h[3:0]);
            chk("head_RCO", out_RCO, h[4]);
            chk("head_modo", out_modo, h[6:5]);
        end
`ifdef RC_STATS_EN
        chk("carry_cnt", carry_cnt, carry_m);
        chk("borrow_cnt", borrow_cnt, borrow_m);
        chk("carry_cnt_cw2", carry2, carry2_m);
        chk("borrow_cnt_cw2", borrow2, borrow2_m);
`endif
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(1'b1, 2'b01, 4'h1, 4'h1, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        int thresh;
        // Reset state
        do_reset(2);
        chk("rst_vld", out_vld, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_outq", {out_modo, out_RCO, out_Q}, 7'h00);

        // Single add, visible two edges after issue
        cyc(1'b1, 2'b01, 4'h5, 4'h3, 1'b0);
        chk("lat_edge1_vld", out_vld, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("lat_edge2_vld", out_vld, 1'b1);
        chk("lat_q", out_Q, 4'h8);
        chk("lat_rco", out_RCO, 1'b0);
        chk("lat_modo", out_modo, 2'b01);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);

        // Mixed operations, hold cycle contributes nothing
        cyc(1'b1, 2'b01, 4'h9, 4'h9, 1'b0);
        cyc(1'b1, 2'b10, 4'h3, 4'h5, 1'b0);
        cyc(1'b1, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc(1'b1, 2'b11, 4'h0, 4'h0, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("mix_count", count, 3);
        chk("mix_h0", {out_modo, out_RCO, out_Q}, 7'b01_1_0010);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("mix_h1", {out_modo, out_RCO, out_Q}, 7'b10_1_1110);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("mix_h2", {out_modo, out_RCO, out_Q}, 7'b11_0_0000);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("mix_drained", empty, 1'b1);

        // Overflow: five results into four slots
        do_reset(1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 2'b01, 4'(i), 4'h1, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("ovf_full", full, 1'b1);
        chk("ovf_count", count, DEPTH);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_head", out_Q, 4'h1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("ovf_fifth_gone", empty, 1'b1);
        chk("ovf_sticky", ovf, 1'b1);

        // Full with simultaneous pop and push
        do_reset(1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'b01, 4'h1, 4'h1, 1'b0);
        cyc(1'b1, 2'b01, 4'h7, 4'h7, 1'b0);
        chk("fp_full", full, 1'b1);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("fp_count", count, DEPTH);
        chk("fp_ovf", ovf, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("fp_last", out_Q, 4'hE);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);

        // Reset discards an in-flight result
        do_reset(1);
        cyc(1'b1, 2'b01, 4'h2, 4'h2, 1'b0);
        do_reset(1);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("midrst_count", count, 0);
        chk("midrst_vld", out_vld, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);

`ifdef RC_STATS_EN
        do_reset(1);
        cyc(1'b1, 2'b01, 4'h9, 4'h9, 1'b0);
        cyc(1'b1, 2'b10, 4'h3, 4'h5, 1'b0);
        cyc(1'b1, 2'b01, 4'h1, 4'h1, 1'b0);
        cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b0);
        chk("st_carry", carry_cnt, 1);
        chk("st_borrow", borrow_cnt, 1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'b01, 4'hF, 4'h2, 1'b1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 2'b00, 4'h0, 4'h0, 1'b1);
        chk("st_sat_cw2", carry2, 2'd3);
`endif

        // Random traffic with varying consumer pressure
        do_reset(1);
        thresh = 2;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) thresh = $urandom_range(0, 4);
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
                    1'($urandom_range(0, 3) < thresh));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
